i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 16, sample width in bits (legal 8..32).
REQ-002 SHALL have parameter TIMEOUT, default 256, clk cycles without a bck rising edge before lock is lost.
REQ-003 SHALL have port clk, input, 1, system clock (48 MHz nominal).
REQ-004 SHALL have port arst_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port bck, input, 1, external I2S bit clock (asynchronous to clk).
REQ-006 SHALL have port lrck, input, 1, external word clock; 0 = left slot, 1 = right slot.
REQ-007 SHALL have port din, input, 1, external serial data, MSB first.
REQ-008 SHALL have port left, output, ADC_WIDTH, last complete left sample.
REQ-009 SHALL have port right, output, ADC_WIDTH, last complete right sample.
REQ-010 SHALL have port valid, output, 1, one-clk pulse when left/right update as a pair.
REQ-011 SHALL have port locked, output, 1, high while frames are being received.
REQ-012 SHALL have port frame_err, output, 1, one-clk pulse when a committed slot held fewer than ADC_WIDTH bits.

Function
REQ-013 SHALL synchronise bck, lrck and din through identical 2-FF chains so that all three stay mutually coherent.
REQ-014 SHALL detect bck rising edges on the synchronised bck; all slot logic SHALL act only on those edges (one clk per edge).
REQ-015 SHALL operate correctly for clk >= 4x bck frequency; behaviour below that ratio is undefined.
REQ-016 SHALL keep lrck_q, the synchronised lrck value sampled at the previous bck edge.
REQ-017 On each bck edge with slot bit count < ADC_WIDTH: SHALL write din into shift-register bit (ADC_WIDTH-1-count) and increment the count; bits at count >= ADC_WIDTH SHALL be ignored and the count SHALL saturate.
REQ-018 A boundary is a bck edge where lrck differs from lrck_q; the din bit on that edge SHALL belong to the previous slot (I2S one-bit delay), be shifted in per REQ-017, and then be committed.
REQ-019 On commit: the word (unfilled LSBs = 0) SHALL go to the channel given by lrck_q; the shift register and count SHALL then clear for the new slot.
REQ-020 State machine HUNT/RUN: reset enters HUNT; in HUNT no commit, valid or frame_err occurs; the first falling boundary (lrck_q=1 to lrck=0) SHALL move to RUN.
REQ-021 In RUN, a rising boundary SHALL commit to the left hold register; a falling boundary SHALL load left <= left hold and right <= committed word, and pulse valid.
REQ-022 valid SHALL be high exactly 4 clk cycles after the bck pin edge that closes the right slot (2 sync + 1 edge + 1 output register).
REQ-023 frame_err SHALL pulse in the same cycle as a RUN commit whose slot count is < ADC_WIDTH; the word is still committed.
REQ-024 A watchdog SHALL count clk cycles since the last bck edge and reload on every edge; reaching TIMEOUT SHALL force HUNT, clear the shift register and count, and leave left/right unchanged.
REQ-025 locked SHALL equal (state == RUN).
REQ-026 A right slot interrupted by timeout SHALL NOT produce valid.

Reset
REQ-027 While arst_n = 0: left = 0, right = 0, valid = 0, frame_err = 0, locked = 0, state = HUNT, hold, shift, count and watchdog = 0, synchronisers = 0.
REQ-028 Release SHALL be synchronous to clk via the system reset synchroniser; after reset the first pair SHALL appear only after one full frame received in RUN.

Structure
REQ-029 Shared package i2s_pkg SHALL hold the HUNT/RUN state encoding, the SYNC_STAGES=2 constant, and the channel constants LEFT=0 / RIGHT=1, shared with the PCM5102 transmitter.
REQ-030 One sub-module, i2s_sync (3-bit 2-FF synchroniser plus bck rising-edge detector), SHALL be instantiated; all other logic stays in i2s_rx.

Verification
REQ-031 Bench: 16 bck per slot, left=16'hA5C3, right=16'h5A3C, 3 frames -> from the 2nd frame on, valid pulses once per frame with left=A5C3, right=5A3C; frame_err never pulses.
REQ-032 Bench: 32 bck per slot carrying 24 data bits (8'h00 pad), ADC_WIDTH=16, left=24'h123456 -> left=16'h1234, no frame_err.
REQ-033 Bench: right slot of 12 bck only, data 12'hFFF -> right=16'hFFF0 and frame_err pulses with valid.
REQ-034 Bench: bck stopped 300 clk mid-right-slot -> locked falls at 256 clk, no valid, left/right unchanged; restart -> locked rises at the next falling boundary.
REQ-035 Bench: arst_n low 3 clk mid-frame -> all outputs 0 immediately; the first valid appears only after HUNT->RUN plus one full frame.
REQ-036 Bench: measure latency from the bck pin edge closing the right slot to valid -> exactly 4 clk.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: state encoding, synchroniser depth and channel constants shared by the I2S receiver
// and the PCM5102 transmitter.
package i2s_pkg;
  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;
  localparam int SYNC_STAGES = 2;
  localparam logic LEFT = 1'b0;
  localparam logic RIGHT = 1'b1;
endpackage

// File: rtl/i2s_rx_if.sv
// i2s_rx_if: parallel PCM sample pair bus produced by the I2S receiver.
interface i2s_rx_if #(parameter int W = 16);
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic valid;
  logic locked;
  logic frame_err;
  modport master(output left, right, valid, locked, frame_err);
  modport slave(input left, right, valid, locked, frame_err);
endinterface

// File: rtl/i2s_sync.sv
// i2s_sync: brings bck/lrck/din into the clk domain through one shared chain and flags bck rises.
// lrck and din are re-registered alongside the edge flag so all three stay aligned.
module i2s_sync import i2s_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic bck,
  input  logic lrck,
  input  logic din,
  output logic rise,
  output logic lrck_s,
  output logic din_s
);
  logic [2:0] chain [SYNC_STAGES];
  logic bck_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chain <= '{default: '0};
      bck_d <= 1'b0;
      rise <= 1'b0;
      lrck_s <= 1'b0;
      din_s <= 1'b0;
    end else begin
      chain[0] <= {bck, lrck, din};
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      bck_d <= chain[SYNC_STAGES-1][2];
      rise <= chain[SYNC_STAGES-1][2] & ~bck_d;
      lrck_s <= chain[SYNC_STAGES-1][1];
      din_s <= chain[SYNC_STAGES-1][0];
    end
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver; hunts for a frame start, then assembles MSB-first slots into
// left/right sample pairs, with a watchdog that drops lock when bck stops.
module i2s_rx import i2s_pkg::*; #(
  parameter int ADC_WIDTH = 16,
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic arst_n,
  input  logic bck,
  input  logic lrck,
  input  logic din,
  i2s_rx_if.master pcm
);
  localparam int CW = $clog2(ADC_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL = CW'(ADC_WIDTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  logic [1:0] rst_q;
  logic rst_n;
  logic rise, lrck_s, din_s, lrck_q;
  logic boundary, timeout, commit;
  logic valid_r, err_r;
  state_t state, state_n;
  logic [ADC_WIDTH-1:0] shift, shift_n, hold, left_r, right_r;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] wd;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_n = rst_q[1];
  i2s_sync u_sync (
    .clk(clk), .rst_n(rst_n), .bck(bck), .lrck(lrck), .din(din),
    .rise(rise), .lrck_s(lrck_s), .din_s(din_s)
  );
  // shift_n/cnt_n already include this edge's bit, so a commit sees the one-bit-delayed LSB
  always_comb begin
    shift_n = shift;
    for (int i = 0; i < ADC_WIDTH; i++)
      if (cnt == CW'(ADC_WIDTH - 1 - i)) shift_n[i] = din_s;
    cnt_n = (cnt == FULL) ? cnt : cnt + 1'b1;
    boundary = rise && (lrck_s != lrck_q);
    timeout = !rise && (wd == TMAX);
    commit = boundary && (state == RUN);
    state_n = timeout ? HUNT : (state == HUNT && boundary && lrck_q == RIGHT) ? RUN : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      lrck_q <= LEFT;
      shift <= '0;
      cnt <= '0;
      wd <= '0;
      hold <= '0;
      left_r <= '0;
      right_r <= '0;
      valid_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      wd <= rise ? '0 : (wd == TMAX) ? wd : wd + 1'b1;
      valid_r <= commit && lrck_q == RIGHT;
      err_r <= commit && cnt_n != FULL;
      if (rise) lrck_q <= lrck_s;
      if (timeout || boundary) begin
        shift <= '0;
        cnt <= '0;
      end else if (rise) begin
        shift <= shift_n;
        cnt <= cnt_n;
      end
      if (commit && lrck_q == LEFT) hold <= shift_n;
      if (commit && lrck_q == RIGHT) begin
        left_r <= hold;
        right_r <= shift_n;
      end
    end
  assign pcm.left = left_r;
  assign pcm.right = right_r;
  assign pcm.valid = valid_r;
  assign pcm.frame_err = err_r;
  assign pcm.locked = (state == RUN);
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: plays I2S slot streams into i2s_rx; a slot-level model queues expected pulses
// that an independent monitor checks whenever valid or frame_err appears.
module tb_i2s_rx;
  localparam int W = 16;
  typedef struct {logic v; logic e; logic [W-1:0] l; logic [W-1:0] r; int c;} ev_t;
  logic clk = 0, arst_n = 1, bck = 0, lrck = 0, din = 0;
  int checks = 0, errors = 0, cyc = 0;
  ev_t exq[$];
  bit lrq[$], dq[$], sb[$];
  bit din_prev = 0, mq = 0, run = 0;
  logic [W-1:0] hold_m = '0, last_l = '0, last_r = '0;
  i2s_rx_if #(.W(W)) pcm();
  i2s_rx #(.ADC_WIDTH(W), .TIMEOUT(256)) dut (
    .clk(clk), .arst_n(arst_n), .bck(bck), .lrck(lrck), .din(din), .pcm(pcm)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic push_slot(input bit l, input int n, input logic [31:0] data, input int dbits);
    for (int k = 0; k < n; k++) begin
      lrq.push_back(l);
      dq.push_back(k < dbits ? data[dbits-1-k] : 1'b0);
    end
  endtask
  // slot-level reference: the bit carried by a boundary edge belongs to the slot just ending
  task automatic model_bit(input bit l, input bit d);
    logic [W-1:0] w;
    ev_t ev;
    sb.push_back(d);
    if (l != mq) begin
      w = '0;
      for (int i = 0; i < W && i < sb.size(); i++) w[W-1-i] = sb[i];
      ev.v = 0; ev.e = sb.size() < W; ev.l = '0; ev.r = '0; ev.c = cyc;
      if (run && !mq) begin
        hold_m = w;
        if (ev.e) exq.push_back(ev);
      end else if (run) begin
        ev.v = 1; ev.l = hold_m; ev.r = w;
        last_l = hold_m; last_r = w;
        exq.push_back(ev);
      end else if (mq) run = 1;
      sb.delete();
      mq = l;
    end
  endtask
  task automatic play_bit();
    bit l, d;
    l = lrq.pop_front();
    d = dq.pop_front();
    @(posedge clk); #1;
    bck = 0; lrck = l; din = din_prev;
    repeat (4) @(posedge clk);
    #1 bck = 1;
    model_bit(l, din_prev);
    din_prev = d;
    repeat (4) @(posedge clk);
    #1 chk("locked", pcm.locked, run);
  endtask
  task automatic play(input int n);
    for (int i = 0; i < n && lrq.size() > 0; i++) play_bit();
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_left"}, pcm.left, 0);
    chk({tag, "_right"}, pcm.right, 0);
    chk({tag, "_valid"}, pcm.valid, 0);
    chk({tag, "_locked"}, pcm.locked, 0);
    chk({tag, "_frame_err"}, pcm.frame_err, 0);
  endtask
  always @(negedge clk)
    if (pcm.valid || pcm.frame_err) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b but none expected (cycle %0d)",
                 pcm.valid, pcm.frame_err, cyc);
      end else begin
        ev_t ev;
        ev = exq.pop_front();
        chk("valid", pcm.valid, ev.v);
        chk("frame_err", pcm.frame_err, ev.e);
        chk("latency", cyc - ev.c, 4);
        if (ev.v) begin
          chk("left", pcm.left, ev.l);
          chk("right", pcm.right, ev.r);
        end
      end
    end
  initial begin
    #1 arst_n = 0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    arst_n = 1;
    repeat (5) @(posedge clk);
    for (int f = 0; f < 4; f++) begin
      push_slot(0, 16, 32'hA5C3, 16);
      push_slot(1, 16, 32'h5A3C, 16);
    end
    play(lrq.size());
    chk("fixed_left", pcm.left, 16'hA5C3);
    chk("fixed_right", pcm.right, 16'h5A3C);
    for (int f = 0; f < 2; f++) begin
      push_slot(0, 32, 32'h123456, 24);
      push_slot(1, 32, $urandom & 32'hFFFFFF, 24);
    end
    play(lrq.size());
    chk("wide_left", pcm.left, 16'h1234);
    for (int f = 0; f < 6; f++) begin
      push_slot(0, 16 + $urandom_range(0, 4), $urandom, 16);
      push_slot(1, 16 + $urandom_range(0, 4), $urandom, 16);
    end
    play(lrq.size());
    push_slot(0, 16, 32'h1357, 16);
    push_slot(1, 12, 32'hFFF, 12);
    push_slot(0, 10, 32'h3FF, 10);
    push_slot(1, 16, $urandom, 16);
    play(lrq.size());
    chk("short_left", pcm.left, 16'h1357);
    chk("short_right", pcm.right, 16'hFFF0);
    push_slot(0, 16, $urandom, 16);
    push_slot(1, 16, $urandom, 16);
    play(24);
    repeat (250) @(posedge clk);
    #1 chk("locked_before_timeout", pcm.locked, 1);
    repeat (8) @(posedge clk);
    #1 chk("locked_after_timeout", pcm.locked, 0);
    repeat (42) @(posedge clk);
    #1 chk("timeout_left_kept", pcm.left, last_l);
    chk("timeout_right_kept", pcm.right, last_r);
    run = 0;
    sb.delete();
    push_slot(0, 16, $urandom, 16);
    push_slot(1, 16, $urandom, 16);
    push_slot(0, 16, $urandom, 16);
    push_slot(1, 16, $urandom, 16);
    play(lrq.size());
    chk("relocked", pcm.locked, 1);
    for (int f = 0; f < 2; f++) begin
      push_slot(0, 16, $urandom, 16);
      push_slot(1, 16, $urandom, 16);
    end
    push_slot(0, 16, $urandom, 16);
    play(8);
    @(posedge clk); #1 bck = 0;
    repeat (3) @(posedge clk);
    #1 arst_n = 0;
    #1 check_zero("midframe_reset");
    repeat (3) @(posedge clk);
    #1 arst_n = 1;
    run = 0; mq = 0; hold_m = '0; last_l = '0; last_r = '0;
    sb.delete();
    play(lrq.size());
    repeat (20) @(posedge clk);
    #1 chk("pending_expected", exq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
